// File: rtl/perspective_divide_iter_if.sv
// Vertex handshake bundle for perspective_divide_iter: upstream vertex in,
// downstream projected vertex plus clip flag out.
interface perspective_divide_iter_if #(
    parameter int WIDTH = 32
);
    logic                  valid_in;
    logic                  ready_out;
    logic [3:0][WIDTH-1:0] vertex_in;
    logic                  valid_out;
    logic                  ready_in;
    logic [3:0][WIDTH-1:0] vertex_out;
    logic                  clipped_out;

    modport master (
        output valid_in, vertex_in, ready_in,
        input  ready_out, valid_out, vertex_out, clipped_out
    );

    modport slave (
        input  valid_in, vertex_in, ready_in,
        output ready_out, valid_out, vertex_out, clipped_out
    );
endinterface

// File: rtl/perspective_divide_iter.sv
// Iterative perspective divide: R = 1/w by restoring division, then {R, z*R, y*R, x*R}.
// Define PERSPECTIVE_DIVIDE_ITER_SATURATE_EN to clamp out-of-range results instead of wrapping.
module perspective_divide_iter #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    perspective_divide_iter_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam int DIV_CYCLES = 2 * FRAC + 1;
    localparam int QW         = DIV_CYCLES;
    localparam int PW         = WIDTH + QW + 1;
    localparam int CW         = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIVIDE   = 2'd1,
        S_MULTIPLY = 2'd2,
        S_OUTPUT   = 2'd3
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [2:0][WIDTH-1:0] xyz;
    logic [WIDTH-1:0]      abs_w;
    logic [WIDTH-1:0]      rem;
    logic [QW-1:0]         quo;
    logic                  w_neg;
    logic [3:0][WIDTH-1:0] vout;
    logic                  clip;
    logic                  accept;
    logic [WIDTH:0]        trial;
    logic [WIDTH:0]        diff;
    logic                  trial_ge;
    logic signed [QW:0]    rs;
    logic signed [PW-1:0]  prod [3];
    logic [3:0][WIDTH-1:0] result;

    // A transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its data stable until that edge, the consumer never
    // waits on valid before raising ready.
    assign accept = (state == S_IDLE) && bus.valid_in;

    function automatic logic [WIDTH-1:0] reduce(input logic signed [PW-1:0] v);
`ifdef PERSPECTIVE_DIVIDE_ITER_SATURATE_EN
        if ((|v[PW-1:WIDTH-1]) && !(&v[PW-1:WIDTH-1]))
            return v[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return v[WIDTH-1:0];
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.valid_in)
                            state_next = (bus.vertex_in[3] == '0) ? S_MULTIPLY : S_DIVIDE;
            S_DIVIDE:   if (cnt == '0) state_next = S_MULTIPLY;
            S_MULTIPLY: state_next = S_OUTPUT;
            S_OUTPUT:   if (bus.ready_in) state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_out   = (state == S_IDLE);
        bus.valid_out   = (state == S_OUTPUT);
        bus.vertex_out  = vout;
        bus.clipped_out = clip;
        state_dbg       = state;
    end

    // Dividend 2^(2*FRAC) is a lone one at its MSB, shifted in on the first step only.
    always_comb begin
        trial    = {rem, (cnt == CW'(DIV_CYCLES - 1))};
        diff     = trial - {1'b0, abs_w};
        trial_ge = (trial >= {1'b0, abs_w});
    end

    always_comb begin
        rs = w_neg ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
        for (int i = 0; i < 3; i++) begin
            prod[i]   = PW'($signed(xyz[i])) * PW'(rs);
            result[i] = reduce(prod[i] >>> FRAC);
        end
        result[3] = reduce(PW'(rs));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt   <= '0;
            xyz   <= '0;
            abs_w <= '0;
            rem   <= '0;
            quo   <= '0;
            w_neg <= 1'b0;
            vout  <= '0;
            clip  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    xyz   <= bus.vertex_in[2:0];
                    w_neg <= bus.vertex_in[3][WIDTH-1];
                    abs_w <= bus.vertex_in[3][WIDTH-1] ? -bus.vertex_in[3] : bus.vertex_in[3];
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= CW'(DIV_CYCLES - 1);
                end
                S_DIVIDE: begin
                    rem <= trial_ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[QW-2:0], trial_ge};
                    cnt <= cnt - 1'b1;
                end
                S_MULTIPLY: begin
                    vout <= result;
                    clip <= w_neg || (abs_w == '0);
                end
                default: ;
            endcase
        end
    end
endmodule
